// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder (serial_adder) and its one-bit cell.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width for a given operand width, $clog2(width), never below 1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Purely combinational one-bit full adder; the single arithmetic cell of serial_adder.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cy
);

    assign s  = a ^ b ^ c;
    assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input (a - b, cout = no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s, fa_cy;
    logic             sub_mode, accept, last;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_mode = sub;
`else
    assign sub_mode = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == LAST_BIT);

    serial_fa_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .cy (fa_cy)
    );

    // Sum bits enter the A shift register as its operand bits leave, so no
    // separate sum shifter is needed; sum_q holds the published result.
    assign a_sh_d = {fa_s, a_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = SHIFT;
            SHIFT:   if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            SHIFT: busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b ^ {WIDTH{sub_mode}};
                        carry_q <= sub_mode ? 1'b1 : cin;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_cy;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        sum_q  <= a_sh_d;
                        cout_q <= fa_cy;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
